// File: rtl/y_writeback_pkg.sv
// y_writeback_pkg: shared constants for the y write-back stage.
//   - FloPoCo exception-field encodings (bits [65:64] of a FloPoCo double)
//   - IEEE-754 binary64 infinity exponent and canonical quiet NaN
//   - FSM state type
//   - log2(): number of bits needed to hold a value (pointer-width helper)
package y_writeback_pkg;

    localparam logic [1:0] FP_EXC_ZERO   = 2'b00;
    localparam logic [1:0] FP_EXC_NORMAL = 2'b01;
    localparam logic [1:0] FP_EXC_INF    = 2'b10;
    localparam logic [1:0] FP_EXC_NAN    = 2'b11;

    localparam logic [10:0] IEEE_EXP_INF = 11'h7FF;
    localparam logic [63:0] IEEE_QNAN    = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    // Bits needed to represent 'value' (minimum 1); log2(63) = 6.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/y_writeback_fifo.sv
// y_writeback_fifo: synchronous FIFO buffering converted results.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset (empties the FIFO)
//   wr_en_i/wr_data_i  write request; accepted when not full, or when a
//                  read happens in the same cycle
//   rd_en_i        pop the head entry (ignored when empty)
//   rd_data_o      head entry (valid while !empty_o)
//   empty_o/full_o occupancy flags
module y_writeback_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign rd_ok     = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/y_writeback.sv
// y_writeback: converts FloPoCo doubles to IEEE binary64, buffers them and
// issues sequential 8-byte stores into the y vector; reports completion
// once row_count stores have been acknowledged.
// Ports:
//   clk, rst (sync, active-low)
//   start, y_base, row_count   run setup (honoured in IDLE/DONE only)
//   push_to_y, v_to_y          incoming results (cannot be back-pressured)
//   req_st, req_vadr, req_data store request (registered)
//   req_stall, rsp_st_ack      memory-side flow control / completions
//   busy, done, overflow       status
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | issuing stores until row_count have been issued
// ST_DRAIN | all stores issued, waiting for remaining acks
// ST_DONE  | all acked; done held until the next start
module y_writeback
    import y_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH      = 64,
    parameter int LOG2_FIFO_DEPTH = log2(FIFO_DEPTH - 1),
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] y_base,
    input  logic [31:0] row_count,
    input  logic        push_to_y,
    input  logic [65:0] v_to_y,
    output logic        req_st,
    output logic [47:0] req_vadr,
    output logic [63:0] req_data,
    input  logic        req_stall,
    input  logic        rsp_st_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    function automatic logic [63:0] to_ieee(input logic [65:0] v);
        logic [63:0] r;
        case (v[65:64])
            FP_EXC_ZERO:   r = {v[63], 63'b0};
            FP_EXC_NORMAL: r = v[63:0];
            FP_EXC_INF:    r = {v[63], IEEE_EXP_INF, 52'b0};
            FP_EXC_NAN:    r = IEEE_QNAN;
            default:       r = IEEE_QNAN;
        endcase
        return r;
    endfunction

    wb_state_e   state_q;
    logic [63:0] conv_d, conv_q;
    logic        conv_vld_q;
    logic [31:0] issued_q, acked_q, row_count_q, outstanding;
    logic [47:0] base_q;
    logic        req_st_q, busy_q, done_q, overflow_q;
    logic [47:0] req_vadr_q;
    logic [63:0] req_data_q;
    logic [63:0] fifo_rdata;
    logic        fifo_empty, fifo_full;
    logic        issue, ack_cnt, ovf_event;

    assign conv_d      = to_ieee(v_to_y);
    assign outstanding = issued_q - acked_q;
    assign issue       = (state_q == ST_RUN) && !fifo_empty && !req_stall &&
                         (outstanding < 32'(MAX_OUTSTANDING));
    // Acks outside a run (e.g. stragglers after reset) are not counted.
    assign ack_cnt     = rsp_st_ack && (state_q == ST_RUN || state_q == ST_DRAIN);
    assign ovf_event   = conv_vld_q && fifo_full && !issue;

    y_writeback_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH),
        .AW    (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (!rst),
        .wr_en_i   (conv_vld_q),
        .wr_data_i (conv_q),
        .rd_en_i   (issue),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            conv_q      <= '0;
            conv_vld_q  <= 1'b0;
            issued_q    <= '0;
            acked_q     <= '0;
            row_count_q <= '0;
            base_q      <= '0;
            req_st_q    <= 1'b0;
            req_vadr_q  <= '0;
            req_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            conv_q     <= conv_d;
            conv_vld_q <= push_to_y;
            req_st_q   <= issue;
            if (issue) begin
                req_vadr_q <= base_q + {13'b0, issued_q, 3'b000};
                req_data_q <= fifo_rdata;
                issued_q   <= issued_q + 32'd1;
            end
            if (ack_cnt)   acked_q    <= acked_q + 32'd1;
            if (ovf_event) overflow_q <= 1'b1;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_q      <= y_base & ~48'h7;
                        row_count_q <= row_count;
                        issued_q    <= '0;
                        acked_q     <= '0;
                        overflow_q  <= 1'b0;
                        if (row_count == 32'd0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue && (issued_q + 32'd1 == row_count_q)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (acked_q == row_count_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_st   = req_st_q;
    assign req_vadr = req_vadr_q;
    assign req_data = req_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: doc/y_writeback.md
# y_writeback

Terminal stage of the MAC datapath. Consumes finished row sums from the intermediator's `push_to_y` / `v_to_y` output and converts each 66-bit FloPoCo double to IEEE-754 binary64. Buffers the results in a FIFO and issues sequential 8-byte store requests into the y vector in coprocessor memory. Reports completion once every expected row has been stored and acknowledged.

## Interface
Parameters:
- `FIFO_DEPTH`, 64: result buffer entries (power of two). The intermediator cannot be back-pressured.
- `LOG2_FIFO_DEPTH`, `log2(FIFO_DEPTH - 1)`: buffer pointer width, from `common.vh`.
- `MAX_OUTSTANDING`, 32: cap on store requests issued but not yet acknowledged.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; latches `y_base` and `row_count`. Honoured only in IDLE or DONE.
- `y_base` in 48: byte address of y[0]; bits [2:0] are ignored (forced 0).
- `row_count` in 32: number of results expected this run; 0 is legal.
- `push_to_y` in 1: a result is valid this cycle.
- `v_to_y` in 66: FloPoCo value. [65:64] = exception, [63] = sign, [62:0] = exponent/fraction.
- `req_st` out 1: store request valid.
- `req_vadr` out 48: store byte address.
- `req_data` out 64: IEEE binary64 store data.
- `req_stall` in 1: memory controller cannot accept a request this cycle.
- `rsp_st_ack` in 1: one store completion per assertion.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: level, high in DONE.
- `overflow` out 1: sticky; a push arrived while the buffer was full.

## Operation
- Format conversion, by `v_to_y[65:64]`:
  - 00 (zero) → {sign, 63'b0}
  - 01 (normal) → `v_to_y[63:0]`
  - 10 (inf) → {sign, 11'h7FF, 52'b0}
  - 11 (NaN) → 64'h7FF8_0000_0000_0000
- Converted data is registered one stage, then written into the FIFO.
- FSM, state IDLE:
  - On `start`, clear `issued`, `acked` and `overflow`, then go to RUN.
  - If `row_count` is 0, go directly to DONE instead.
- FSM, state RUN:
  - Issue a store whenever all three hold: FIFO not empty, `req_stall` low, and (`issued` − `acked`) < `MAX_OUTSTANDING`.
  - Address of each store = `y_base` + 8·`issued`; `issued` then increments.
  - When `issued` reaches `row_count`, go to DRAIN.
- FSM, state DRAIN: wait until `acked` equals `row_count`, then go to DONE.
- FSM, state DONE: hold `done`. `start` begins a new run.
- Out-of-run or excess data: pushes received in IDLE/DONE, or beyond `row_count`, are still buffered. They are issued only under a following run.
- Counters are 32-bit. Address arithmetic is 48-bit and wraps modulo 2^48.
- The outstanding count is computed as `issued` − `acked`, so no separate counter is needed.

## Timing
- Reset values: `req_st`=0, `req_vadr`=0, `req_data`=0, `busy`=0, `done`=0, `overflow`=0. State is IDLE, FIFO empty, counters 0.
- Latency from push at cycle t:
  - FIFO write at t+1.
  - `req_st` high at the earliest at t+3 (FIFO output registered, request registered).
- `req_st` is asserted only on a cycle that immediately follows a cycle in which `req_stall` was low. A request is never held across a stall; it is simply not issued.
- Simultaneous push and pop on a full FIFO: the pop frees the slot and the push is accepted. `overflow` stays 0.
- Push into a full FIFO with no pop: the data is dropped and `overflow` sets; it is cleared only by reset or `start`.
- An ack arriving in the same cycle as an issue: both counters update in that cycle and the outstanding count is unchanged.
- `start` during RUN or DRAIN is ignored.
- Reset mid-run returns to IDLE immediately and discards FIFO contents. Late acks arriving after reset are ignored.

## Structure
- Constants go in `common.vh`:
  - FloPoCo exception encodings.
  - IEEE inf and NaN constants.
  - the `log2` function.
- Sub-module: reuse `std_fifo` (width 64, depth `FIFO_DEPTH`). Drive its reset with `!rst`.
- Conversion is a combinational function inside this module; FSM and counters are in the same module.

## Test plan
- Basic run: `y_base`=0x1000, `row_count`=3, three pushes of normal 1.0 (66'h1_3FF0_0000_0000_0000), no stall, immediate acks → stores to 0x1000, 0x1008, 0x1010 with data 0x3FF0000000000000; `done` high after the 3rd ack.
- Exception encodings: push zero-negative, inf-positive, NaN → data 0x8000000000000000, 0x7FF0000000000000, 0x7FF8000000000000.
- Stall: `req_stall` held high for 20 cycles during a 10-value burst → no `req_st` while stalled; all 10 stores issued afterwards, in order, at consecutive addresses; `overflow`=0.
- Outstanding cap: `MAX_OUTSTANDING`=4 with acks withheld → exactly 4 stores issued; each ack released allows exactly one more store.
- Overflow: `FIFO_DEPTH`=4, stall held, 6 pushes → `overflow`=1. After `start`, `overflow`=0.
- Edge cases:
  - `row_count`=0 → `done` one cycle after `start`, with no `req_st`.
  - Reset asserted mid-DRAIN → IDLE, all outputs at their reset values.
